fifo_bridge_mc: RTL



---
 rtl/fifo_bridge_mc.sv | 371 +++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fifo_bridge_mc.sv
// AXI4-Lite bridge between software and NUM_CH wide input/output FIFO pairs.
// Staging words assemble input words; output words are popped into a read shadow.
module fifo_wrapper #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int PROG_EMPTY = 4,
  parameter int PROG_FULL  = 60,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic [CW-1:0]         count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (do_wr && !do_rd)      count_d = count_q + 1'b1;
    else if (!do_wr && do_rd) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

  // First-word-fall-through: the head word is always visible on dout.
  assign dout       = mem_q[rd_ptr_q];
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign prog_full  = (count_q >= CW'(PROG_FULL));
  assign prog_empty = (count_q <= CW'(PROG_EMPTY));
  assign count      = count_q;
endmodule

module fifo_bridge_mc #(
  parameter int AXI_ADDR_WIDTH       = 12,
  parameter int AXI_DATA_WIDTH       = 32,
  parameter int NUM_CH               = 4,
  parameter int FIFO_DATA_WIDTH      = 256,
  parameter int IN_FIFO_DEPTH        = 64,
  parameter int OUT_FIFO_DEPTH       = 64,
  parameter int IN_FIFO_ALMOST_EMPTY = 4,
  parameter int OUT_FIFO_ALMOST_FULL = OUT_FIFO_DEPTH - 4
) (
  input  logic                          i_axi_clk,
  input  logic                          i_axi_reset,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_axi_awaddr,
  input  logic                          i_axi_awvalid,
  output logic                          o_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     i_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   i_axi_wstrb,
  input  logic                          i_axi_wvalid,
  output logic                          o_axi_wready,
  output logic [1:0]                    o_axi_bresp,
  output logic                          o_axi_bvalid,
  input  logic                          i_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_axi_araddr,
  input  logic                          i_axi_arvalid,
  output logic                          o_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]     o_axi_rdata,
  output logic [1:0]                    o_axi_rresp,
  output logic                          o_axi_rvalid,
  input  logic                          i_axi_rready,
  input  logic [NUM_CH-1:0]             i_in_fifo_rd_en,
  output logic [NUM_CH*FIFO_DATA_WIDTH-1:0] o_in_fifo_data_out,
  output logic [NUM_CH-1:0]             o_in_fifo_empty,
  output logic [NUM_CH-1:0]             o_in_fifo_alm_empty,
  input  logic [NUM_CH-1:0]             i_out_fifo_wr_en,
  input  logic [NUM_CH*FIFO_DATA_WIDTH-1:0] i_out_fifo_data_in,
  output logic [NUM_CH-1:0]             o_out_fifo_full,
  output logic [NUM_CH-1:0]             o_out_fifo_alm_full
);
  localparam int DW     = AXI_DATA_WIDTH;
  localparam int FDW    = FIFO_DATA_WIDTH;
  localparam int WPW    = FDW / DW;
  localparam int SW     = DW / 8;
  localparam int IDX_W  = AXI_ADDR_WIDTH - 2;
  localparam int CI_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WI_W   = (WPW > 1) ? $clog2(WPW) : 1;
  localparam int ICW    = $clog2(IN_FIFO_DEPTH + 1);
  localparam int OCW    = $clog2(OUT_FIFO_DEPTH + 1);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_PUSH, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} r_state_e;
  typedef enum logic [2:0] {A_STG, A_OUT, A_STAT, A_CTRL, A_BAD} acc_e;

  function automatic acc_e decode(input logic [IDX_W-1:0] idx);
    logic [4:0] off;
    off = idx[4:0];
    if (int'(idx[IDX_W-1:5]) >= NUM_CH) return A_BAD;
    if (int'(off) < WPW)                return A_STG;
    if (int'(off) < 2 * WPW)            return A_OUT;
    if (off == 5'd30)                   return A_STAT;
    if (off == 5'd31)                   return A_CTRL;
    return A_BAD;
  endfunction

  function automatic logic [7:0] sat8(input int n);
    return (n > 255) ? 8'hFF : n[7:0];
  endfunction

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [IDX_W-1:0] awidx_q, awidx_d, aridx_q, aridx_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [NUM_CH-1:0] flush_in_q, flush_in_d, flush_out_q, flush_out_d;
  logic [NUM_CH-1:0] sticky_q, sticky_d, sticky_clr, sticky_set;
  logic [DW-1:0] staging_q [NUM_CH][WPW];
  logic [DW-1:0] staging_d [NUM_CH][WPW];
  logic [DW-1:0] shadow_q  [NUM_CH][WPW];
  logic [DW-1:0] shadow_d  [NUM_CH][WPW];
  logic [DW-1:0] status    [NUM_CH];
  logic [FDW-1:0] in_din [NUM_CH];
  logic [FDW-1:0] out_dout [NUM_CH];
  logic [ICW-1:0] in_cnt [NUM_CH];
  logic [OCW-1:0] out_cnt [NUM_CH];
  logic [NUM_CH-1:0] in_full, in_wr_en, out_empty, out_rd_en;
  logic [NUM_CH-1:0] in_pfull_unused, out_pempty_unused;
  logic awready_c, wready_c, arready_c;
  acc_e w_kind, r_kind;
  logic [CI_W-1:0] w_ch, r_ch;
  logic [4:0] w_off, r_off;

  assign w_kind = decode(awidx_q);
  assign r_kind = decode(aridx_q);
  assign w_ch   = CI_W'(awidx_q[IDX_W-1:5]);
  assign r_ch   = CI_W'(aridx_q[IDX_W-1:5]);
  assign w_off  = awidx_q[4:0];
  assign r_off  = aridx_q[4:0];

  // Write path: address and data are captured independently, then executed together.
  always_comb begin
    w_state_d   = w_state_q;
    aw_have_d   = aw_have_q;
    w_have_d    = w_have_q;
    awidx_d     = awidx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bresp_d     = bresp_q;
    staging_d   = staging_q;
    flush_in_d  = '0;
    flush_out_d = '0;
    sticky_clr  = '0;
    in_wr_en    = '0;
    awready_c   = 1'b0;
    wready_c    = 1'b0;
    o_axi_bvalid = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_c = !aw_have_q;
        wready_c  = !w_have_q;
        if (awready_c && i_axi_awvalid) begin
          aw_have_d = 1'b1;
          awidx_d   = i_axi_awaddr[AXI_ADDR_WIDTH-1:2];
        end
        if (wready_c && i_axi_wvalid) begin
          w_have_d = 1'b1;
          wdata_d  = i_axi_wdata;
          wstrb_d  = i_axi_wstrb;
        end
        if (aw_have_q && w_have_q) begin
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          w_state_d = W_RESP;
          case (w_kind)
            A_STG: begin
              for (int b = 0; b < SW; b++)
                if (wstrb_q[b]) staging_d[w_ch][WI_W'(w_off)][b*8 +: 8] = wdata_q[b*8 +: 8];
              if (w_off == 5'(WPW - 1)) w_state_d = W_PUSH;
            end
            A_CTRL: begin
              flush_in_d[w_ch]  = wdata_q[0];
              flush_out_d[w_ch] = wdata_q[1];
              sticky_clr[w_ch]  = wdata_q[2];
              if (wdata_q[3])
                for (int k = 0; k < WPW; k++) staging_d[w_ch][k] = '0;
            end
            default: bresp_d = RESP_SLVERR;
          endcase
        end
      end
      W_PUSH: begin
        if (!in_full[w_ch]) begin
          in_wr_en[w_ch] = 1'b1;
          w_state_d      = W_RESP;
        end
      end
      default: begin
        o_axi_bvalid = 1'b1;
        if (i_axi_bready) w_state_d = W_IDLE;
      end
    endcase
  end

  // Read path: accept, execute (pop/snapshot), then hold the response.
  always_comb begin
    r_state_d    = r_state_q;
    aridx_d      = aridx_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    shadow_d     = shadow_q;
    out_rd_en    = '0;
    sticky_set   = '0;
    arready_c    = 1'b0;
    o_axi_rvalid = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_c = i_axi_arvalid;
        if (i_axi_arvalid) begin
          aridx_d   = i_axi_araddr[AXI_ADDR_WIDTH-1:2];
          r_state_d = R_EXEC;
        end
      end
      R_EXEC: begin
        r_state_d = R_RESP;
        rresp_d   = RESP_OKAY;
        case (r_kind)
          A_STG:  rdata_d = staging_q[r_ch][WI_W'(r_off)];
          A_STAT: rdata_d = status[r_ch];
          A_OUT: begin
            if (r_off != 5'(WPW)) begin
              rdata_d = shadow_q[r_ch][WI_W'(r_off - 5'(WPW))];
            end else if (!out_empty[r_ch]) begin
              out_rd_en[r_ch] = 1'b1;
              for (int k = 0; k < WPW; k++) shadow_d[r_ch][k] = out_dout[r_ch][k*DW +: DW];
              rdata_d = out_dout[r_ch][DW-1:0];
            end else begin
              rdata_d          = '0;
              rresp_d          = RESP_SLVERR;
              sticky_set[r_ch] = 1'b1;
            end
          end
          default: begin
            rdata_d = DW'(32'hDEADBEEF);
            rresp_d = RESP_SLVERR;
          end
        endcase
      end
      default: begin
        o_axi_rvalid = 1'b1;
        if (i_axi_rready) r_state_d = R_IDLE;
      end
    endcase
  end

  always_comb begin
    sticky_d = (sticky_q & ~sticky_clr) | sticky_set;
    for (int c = 0; c < NUM_CH; c++) begin
      in_din[c] = '0;
      for (int k = 0; k < WPW; k++) in_din[c][k*DW +: DW] = staging_q[c][k];
      status[c]        = '0;
      status[c][0]     = in_full[c];
      status[c][1]     = o_in_fifo_empty[c];
      status[c][2]     = out_empty[c];
      status[c][3]     = o_out_fifo_full[c];
      status[c][4]     = (w_state_q == W_PUSH) && (w_ch == CI_W'(c));
      status[c][5]     = sticky_q[c];
      status[c][15:8]  = sat8(int'(in_cnt[c]));
      status[c][23:16] = sat8(int'(out_cnt[c]));
    end
  end

  always_ff @(posedge i_axi_clk) begin
    if (i_axi_reset) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      aw_have_q   <= 1'b0;
      w_have_q    <= 1'b0;
      awidx_q     <= '0;
      aridx_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bresp_q     <= RESP_OKAY;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      flush_in_q  <= '0;
      flush_out_q <= '0;
      sticky_q    <= '0;
      staging_q   <= '{default: '0};
      shadow_q    <= '{default: '0};
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      aw_have_q   <= aw_have_d;
      w_have_q    <= w_have_d;
      awidx_q     <= awidx_d;
      aridx_q     <= aridx_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      flush_in_q  <= flush_in_d;
      flush_out_q <= flush_out_d;
      sticky_q    <= sticky_d;
      staging_q   <= staging_d;
      shadow_q    <= shadow_d;
    end
  end

  assign o_axi_awready = awready_c && !i_axi_reset;
  assign o_axi_wready  = wready_c && !i_axi_reset;
  assign o_axi_arready = arready_c && !i_axi_reset;
  assign o_axi_bresp   = bresp_q;
  assign o_axi_rresp   = rresp_q;
  assign o_axi_rdata   = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0], in_pfull_unused, out_pempty_unused};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_wrapper #(
      .DATA_WIDTH(FDW), .DEPTH(IN_FIFO_DEPTH),
      .PROG_EMPTY(IN_FIFO_ALMOST_EMPTY), .PROG_FULL(IN_FIFO_DEPTH), .CW(ICW)
    ) u_in_fifo (
      .clk(i_axi_clk), .rst(i_axi_reset | flush_in_q[c]),
      .wr_en(in_wr_en[c]), .din(in_din[c]),
      .rd_en(i_in_fifo_rd_en[c]), .dout(o_in_fifo_data_out[c*FDW +: FDW]),
      .full(in_full[c]), .empty(o_in_fifo_empty[c]),
      .prog_full(in_pfull_unused[c]), .prog_empty(o_in_fifo_alm_empty[c]),
      .count(in_cnt[c])
    );
    fifo_wrapper #(
      .DATA_WIDTH(FDW), .DEPTH(OUT_FIFO_DEPTH),
      .PROG_EMPTY(0), .PROG_FULL(OUT_FIFO_ALMOST_FULL), .CW(OCW)
    ) u_out_fifo (
      .clk(i_axi_clk), .rst(i_axi_reset | flush_out_q[c]),
      .wr_en(i_out_fifo_wr_en[c]), .din(i_out_fifo_data_in[c*FDW +: FDW]),
      .rd_en(out_rd_en[c]), .dout(out_dout[c]),
      .full(o_out_fifo_full[c]), .empty(out_empty[c]),
      .prog_full(o_out_fifo_alm_full[c]), .prog_empty(out_pempty_unused[c]),
      .count(out_cnt[c])
    );
  end
endmodule
